// File: rtl/fib_slice_engine.sv
// fib_slice_engine: multi-cycle Fibonacci generator using a SLICE-bit-per-cycle adder.
// Optional trace outputs term_valid/term are enabled by defining FIB_SLICE_TRACE_EN.
module fib_slice_engine #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] fib,
    output logic             overflow
`ifdef FIB_SLICE_TRACE_EN
    ,
    output logic             term_valid,
    output logic [WIDTH-1:0] term
`endif
);
    localparam int S  = WIDTH / SLICE;
    localparam int SW = (S > 1) ? $clog2(S) : 1;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_cfg
            $error("fib_slice_engine: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_n, r_k;
    logic [WIDTH-1:0] r_a, r_b, r_sum, r_fib, w_sum;
    logic [SW-1:0]    r_slice;
    logic             r_carry, r_busy, r_done, r_ovf;
    logic [SLICE-1:0] w_a_sl, w_b_sl, w_s;
    logic             w_c, w_last, w_fin;
    logic [IDX_W-1:0] w_k_next;

    assign w_a_sl   = r_a[int'(r_slice)*SLICE +: SLICE];
    assign w_b_sl   = r_b[int'(r_slice)*SLICE +: SLICE];
    assign {w_c, w_s} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE+1)'(r_carry);
    assign w_k_next = r_k + 1'b1;
    assign w_last   = (r_state == ADD) && (r_slice == SW'(S-1));
    assign w_fin    = w_last && (w_k_next == r_n);

    // Merge the current slice result into the partially assembled sum.
    always_comb begin
        w_sum = r_sum;
        w_sum[int'(r_slice)*SLICE +: SLICE] = w_s;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ((n >= IDX_W'(2)) ? ADD : FIN) : IDLE;
            ADD:     w_next = w_fin ? IDLE : ADD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n     <= '0;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_fib   <= '0;
            r_slice <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_n     <= n;
                r_a     <= '0;
                r_b     <= WIDTH'(1);
                r_k     <= IDX_W'(1);
                r_carry <= 1'b0;
                r_slice <= '0;
                r_ovf   <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state == ADD) begin
                if (w_last) begin
                    r_carry <= 1'b0;
                    r_slice <= '0;
                    r_a     <= r_b;
                    r_b     <= w_sum;
                    r_k     <= w_k_next;
                    r_ovf   <= r_ovf | w_c;
                    if (w_fin) begin
                        r_fib  <= w_sum;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end else begin
                    r_carry <= w_c;
                    r_slice <= r_slice + 1'b1;
                    r_sum   <= w_sum;
                end
            end else if (r_state == FIN) begin
                r_fib  <= (r_n != '0) ? WIDTH'(1) : '0;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign fib      = r_fib;
    assign overflow = r_ovf;

`ifdef FIB_SLICE_TRACE_EN
    logic             r_tv;
    logic [WIDTH-1:0] r_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tv   <= 1'b0;
            r_term <= '0;
        end else begin
            r_tv <= w_last;
            if (w_last) r_term <= w_sum;
        end
    end

    assign term_valid = r_tv;
    assign term       = r_term;
`endif
endmodule

// File: tb/tb_fib_slice_engine.sv
// tb_fib_slice_engine: directed self-checking bench for fib_slice_engine
// (default 32/8 instance plus a 16/16 single-cycle-add instance).
module tb_fib_slice_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  n0 = '0, n1 = '0;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [31:0] fib0;
    logic [15:0] fib1;
    int          checks = 0;
    int          errors = 0;
`ifdef FIB_SLICE_TRACE_EN
    logic        tv0, tv1;
    logic [31:0] term0;
    logic [15:0] term1;
`endif

    always #5 clk = ~clk;

    fib_slice_engine #(.WIDTH(32), .SLICE(8), .IDX_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .n(n0),
        .busy(busy0), .done(done0), .fib(fib0), .overflow(ovf0)
`ifdef FIB_SLICE_TRACE_EN
        , .term_valid(tv0), .term(term0)
`endif
    );

    fib_slice_engine #(.WIDTH(16), .SLICE(16), .IDX_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .n(n1),
        .busy(busy1), .done(done1), .fib(fib1), .overflow(ovf1)
`ifdef FIB_SLICE_TRACE_EN
        , .term_valid(tv1), .term(term1)
`endif
    );

    // Drive start for one edge (E0); returns #1 after E0.
    task automatic launch(input bit sel, input logic [7:0] nn);
        if (sel) begin start1 = 1'b1; n1 = nn; end
        else     begin start0 = 1'b1; n0 = nn; end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts edges until done is seen #1 after an edge; bounded.
    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (!(sel ? done1 : done0) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!(sel ? done1 : done0)) begin
            errors++;
            $display("FAIL wait_done: no done after %0d cycles, expected a pulse", cyc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy0, done0, ovf0, busy1, done1, ovf1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {busy0, done0, ovf0, busy1, done1, ovf1});
        end
        checks++;
        if (fib0 !== 32'd0 || fib1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_fib: got %0d/%0d expected 0/0", fib0, fib1);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_n10;
        int c;
        launch(1'b0, 8'd10);
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL n10_busy_e0: got %b expected 1", busy0); end
        wait_done(1'b0, c);
        checks++;
        if (c !== 36) begin errors++; $display("FAIL n10_latency: got %0d expected 36", c); end
        checks++;
        if (fib0 !== 32'd55) begin errors++; $display("FAIL n10_fib: got %0d expected 55", fib0); end
        checks++;
        if (ovf0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL n10_ovf_busy: got %b%b expected 00", ovf0, busy0);
        end
        @(posedge clk); #1;
        checks++;
        if (done0 !== 1'b0 || fib0 !== 32'd55) begin
            errors++; $display("FAIL n10_pulse_hold: got done=%b fib=%0d expected 0/55", done0, fib0);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        launch(1'b0, 8'd0);
        wait_done(1'b0, c);
        checks++;
        if (c !== 1 || fib0 !== 32'd0) begin
            errors++; $display("FAIL n0: got lat=%0d fib=%0d expected 1/0", c, fib0);
        end
        launch(1'b0, 8'd1);
        checks++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy0, done0);
        end
        wait_done(1'b0, c);
        checks++;
        if (c !== 1 || fib0 !== 32'd1) begin
            errors++; $display("FAIL n1: got lat=%0d fib=%0d expected 1/1", c, fib0);
        end
    endtask

    task automatic test_overflow;
        int c;
        launch(1'b0, 8'd47);
        wait_done(1'b0, c);
        checks++;
        if (c !== 184 || fib0 !== 32'hB11924E1 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL n47: got lat=%0d fib=%h ovf=%b expected 184/b11924e1/0", c, fib0, ovf0);
        end
        launch(1'b0, 8'd48);
        wait_done(1'b0, c);
        checks++;
        if (fib0 !== 32'd512559680 || ovf0 !== 1'b1) begin
            errors++; $display("FAIL n48: got fib=%0d ovf=%b expected 512559680/1", fib0, ovf0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ovf0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf0); end
        launch(1'b0, 8'd2);
        checks++;
        if (ovf0 !== 1'b0 || fib0 !== 32'd512559680) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b fib=%0d expected 0/512559680", ovf0, fib0);
        end
        wait_done(1'b0, c);
        checks++;
        if (c !== 4 || fib0 !== 32'd1) begin
            errors++; $display("FAIL n2: got lat=%0d fib=%0d expected 4/1", c, fib0);
        end
    endtask

    task automatic test_busy_ignore;
        int c;
        launch(1'b0, 8'd20);
        repeat (9) @(posedge clk);
        #1;
        launch(1'b0, 8'd5);
        wait_done(1'b0, c);
        checks++;
        if (c + 10 !== 76 || fib0 !== 32'd6765) begin
            errors++; $display("FAIL busy_ignore: got lat=%0d fib=%0d expected 76/6765", c + 10, fib0);
        end
    endtask

    task automatic test_async_reset;
        int c;
        int seen;
        launch(1'b0, 8'd30);
        repeat (49) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || fib0 !== 32'd0 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b fib=%0d ovf=%b expected all 0", busy0, done0, fib0, ovf0);
        end
        #13 rst_n = 1'b1;
        seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done0 || busy0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        launch(1'b0, 8'd12);
        wait_done(1'b0, c);
        checks++;
        if (c !== 44 || fib0 !== 32'd144) begin
            errors++; $display("FAIL n12: got lat=%0d fib=%0d expected 44/144", c, fib0);
        end
    endtask

    task automatic test_single_slice;
        int c;
        launch(1'b1, 8'd24);
        wait_done(1'b1, c);
        checks++;
        if (c !== 23 || fib1 !== 16'd46368 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL s1_n24: got lat=%0d fib=%0d ovf=%b expected 23/46368/0", c, fib1, ovf1);
        end
        launch(1'b1, 8'd25);
        wait_done(1'b1, c);
        checks++;
        if (c !== 24 || fib1 !== 16'd9489 || ovf1 !== 1'b1) begin
            errors++; $display("FAIL s1_n25: got lat=%0d fib=%0d ovf=%b expected 24/9489/1", c, fib1, ovf1);
        end
    endtask

`ifdef FIB_SLICE_TRACE_EN
    task automatic test_trace;
        logic [15:0] exp_t [5];
        logic [15:0] got [$];
        int          cyc;
        exp_t = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
        launch(1'b1, 8'd1);
        cyc = 0;
        while (!done1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (tv1) got.push_back(term1);
        end
        checks++;
        if (got.size() !== 0) begin errors++; $display("FAIL trace_n1: got %0d pulses expected 0", got.size()); end
        launch(1'b1, 8'd6);
        if (tv1) got.push_back(term1);
        cyc = 0;
        while (!done1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (tv1) got.push_back(term1);
        end
        checks++;
        if (got.size() !== 5) begin
            errors++; $display("FAIL trace_count: got %0d expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp_t[i]) begin
                    errors++; $display("FAIL trace_term%0d: got %0d expected %0d", i, got[i], exp_t[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_n10;
        test_back_to_back;
        test_overflow;
        test_busy_ignore;
        test_async_reset;
        test_single_slice;
`ifdef FIB_SLICE_TRACE_EN
        test_trace;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fib_slice_engine.md
Name: fib_slice_engine

Overview:
- Parametrised multi-cycle Fibonacci term generator built around a WIDTH-bit adder evaluated SLICE bits per clock, with the carry held in a register between slices.
- Generalises the single-bit full-adder cell to a configurable-width, sequential adder datapath with a start/busy/done handshake and sticky overflow detection.
- Sits between the analyser's control logic, which issues a term index, and the result/statistics logic, which consumes the term.

Parameters:
- WIDTH, 32, bit width of the Fibonacci terms and the result. Must be a multiple of SLICE; otherwise elaboration stops with an error.
- SLICE, 8, adder bits evaluated per clock. S = WIDTH/SLICE cycles per addition.
- IDX_W, 8, bit width of the requested term index n.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only when the engine is in IDLE.
- n  input  IDX_W  index of the requested term (F0=0, F1=1); captured when start is accepted.
- busy  output  1  high from the edge that accepts start until the completion edge.
- done  output  1  one-cycle completion pulse.
- fib  output  WIDTH  F(n) mod 2^WIDTH; holds its value until the next completion.
- overflow  output  1  sticky; set if any addition in the current run carried out of bit WIDTH-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, fib=0, overflow=0; internal a, b, carry, slice counter and k cleared. Asserting rst_n mid-run aborts the run; no done pulse follows.
- States: IDLE, ADD, FIN.
- IDLE, start=1 at edge E0:
  - capture n; a=0, b=1, k=1, carry=0, slice=0; overflow=0; busy=1.
  - next state is ADD if n>=2, else FIN.
  - done is deasserted at E0 if it was high.
- ADD, one slice per cycle:
  - {carry, sum[slice]} = a[slice] + b[slice] + carry, where a[slice] denotes bits SLICE*slice .. SLICE*slice+SLICE-1.
  - The carry register is used only between slices; it is cleared at the start of every addition.
  - On the last slice (slice=S-1): final carry ORs into overflow; a<=b; b<=full sum; k<=k+1; slice<=0.
  - If the new k equals n: fib<=sum, done<=1, busy<=0, state<=IDLE, all at that same edge.
- FIN (n<2 only): at the next edge, fib<=(n==0 ? 0 : 1), done<=1, busy<=0, state<=IDLE.
- Latency: done is high in the cycle after edge E0 + T, where T = 1 for n<2 and T = (n-1)*S for n>=2. The done pulse lasts exactly one cycle.
- Handshake and boundary rules:
  - start while busy=1 is ignored, with no effect on state, n or outputs.
  - start in the done cycle is accepted, because the engine is already in IDLE.
  - n is not re-sampled during a run.
  - fib and overflow are stable from the done edge until the next completion or reset.
  - A new accepted start clears overflow; fib keeps its old value until the next completion.
- Wrap-around: sums are truncated mod 2^WIDTH, and iteration continues after overflow.
- SLICE=WIDTH is legal: S=1, one addition per cycle.

Optional Feature:
- Macro: FIB_SLICE_TRACE_EN.
- When defined:
  - extra outputs term_valid (1 bit) and term (WIDTH bits) are present.
  - term_valid pulses for one cycle at every completed addition in ADD, with term = the new sum.
  - for n<2, term_valid never pulses.
  - both outputs reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Default parameters (S=4). Reset, then start with n=10 -> busy=1 from E0; done pulses in the cycle after E0+36; fib=55; overflow=0; busy=0 with done.
- n=0, then n=1 back-to-back, with the second start asserted in the done cycle -> fib=0 done after E0+1; second run accepted immediately; fib=1 done after its E0+1.
- n=47 -> fib=2971215073 (0xB11924E1), overflow=0. n=48 -> fib=512559680 (4807526976 mod 2^32), overflow=1, which then clears when the next start is accepted.
- Start n=20, pulse start with n=5 while busy at cycle E0+10 -> ignored; result fib=6765 at E0+76.
- Start n=30, drive rst_n=0 asynchronously at E0+50 -> all outputs 0 immediately; no done pulse follows; a later start with n=12 gives fib=144.
- WIDTH=16, SLICE=16 (S=1), n=24 -> fib=46368, overflow=0, done after E0+23. Same configuration with n=25 -> fib=75025-65536=9489, overflow=1. With FIB_SLICE_TRACE_EN defined: n=6 gives term_valid pulses with term sequence 1, 2, 3, 5, 8.
